// File: rtl/swing_pkg.sv
// swing_pkg: shared types and constants for the swing serial transmitter.
//   swing_state_t   : framing FSM state encoding
//   SWING_DATA_BITS : data bits per frame (three nibbles)
//   SWING_NIBBLE_W  : width of each input nibble
package swing_pkg;
   localparam int SWING_DATA_BITS = 12;
   localparam int SWING_NIBBLE_W  = 4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } swing_state_t;
endpackage

// File: rtl/swing_bit_timer.sv
// swing_bit_timer: counts CLKS_PER_BIT cycles per serial bit.
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high
//   clear   : hold the counter at zero (line idle)
//   bit_end : high on the final cycle of each bit
// The counter reloads to zero on every bit boundary, so CLKS_PER_BIT=1
// simply gives bit_end on every non-cleared cycle.
module swing_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_end
);
   localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

   logic [7:0] cnt;

   assign bit_end = !clear && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end
endmodule

// File: rtl/swing_tx.sv
// swing_tx: framed serial transmitter for one {AND, B, A} nibble triple.
// Frame: start(0), 12 data bits LSB first, [even parity], stop(1).
// Optional parity bit: define SWING_TX_PARITY_EN.
// Ports:
//   clk, reset        : system clock; asynchronous active-high reset
//   A_in/B_in/AND_in  : nibbles forming word bits [3:0]/[7:4]/[11:8]
//   in_valid/in_ready : acceptance handshake (ready only in IDLE)
//   tx_out            : serial line, idles high (registered)
//   tx_busy           : frame in progress (registered)
//   frame_done        : one-cycle pulse on the last cycle of STOP
//
// state  | meaning
// IDLE   | line high, waiting for a triple
// START  | start bit (low)
// DATA   | 12 data bits, word bit 0 first
// PARITY | even parity over the word (optional build)
// STOP   | stop bit (high)
module swing_tx
   import swing_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [SWING_NIBBLE_W-1:0] A_in,
   input  logic [SWING_NIBBLE_W-1:0] B_in,
   input  logic [SWING_NIBBLE_W-1:0] AND_in,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      tx_out,
   output logic                      tx_busy,
   output logic                      frame_done
);
   localparam logic [3:0] LAST_IDX = 4'(SWING_DATA_BITS - 1);

   swing_state_t               state, state_nxt;
   logic [SWING_DATA_BITS-1:0] shreg, shreg_nxt;
   logic [3:0]                 bit_idx, bit_idx_nxt;
   logic                       tx_nxt;
   logic                       bit_end;
   logic [SWING_DATA_BITS-1:0] word;
`ifdef SWING_TX_PARITY_EN
   logic                       par, par_nxt;
`endif

   assign word       = {AND_in, B_in, A_in};
   assign in_ready   = (state == IDLE);
   assign frame_done = (state == STOP) && bit_end;

   swing_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == IDLE),
      .bit_end (bit_end)
   );

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_idx_nxt = bit_idx;
      tx_nxt      = 1'b1;
`ifdef SWING_TX_PARITY_EN
      par_nxt     = par;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt   = START;
               shreg_nxt   = word;
               bit_idx_nxt = '0;
`ifdef SWING_TX_PARITY_EN
               par_nxt     = ^word;
`endif
            end
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_IDX) begin
`ifdef SWING_TX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  bit_idx_nxt = bit_idx + 4'd1;
                  shreg_nxt   = shreg >> 1;
               end
            end
         end
`ifdef SWING_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_nxt = STOP;
         end
`endif
         STOP: begin
            if (bit_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // tx_out is registered, so it is driven from the state being entered.
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
`ifdef SWING_TX_PARITY_EN
         PARITY:  tx_nxt = par_nxt;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
`ifdef SWING_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_idx <= bit_idx_nxt;
         tx_out  <= tx_nxt;
         tx_busy <= (state_nxt != IDLE);
`ifdef SWING_TX_PARITY_EN
         par     <= par_nxt;
`endif
      end
   end
endmodule

// File: tb/tb_swing_tx.sv
module tb_swing_tx;
`ifdef SWING_TX_PARITY_EN
   localparam int CPB   = 1;
   localparam int NBITS = 15;
`else
   localparam int CPB   = 4;
   localparam int NBITS = 14;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [3:0] a, b, andn;
   logic       in_ready, tx_out, tx_busy, frame_done;

   int n_assert = 0;
   int n_fail   = 0;
   bit exp_q[$];

   swing_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .A_in       (a),
      .B_in       (b),
      .AND_in     (andn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_out     (tx_out),
      .tx_busy    (tx_busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(logic [11:0] w);
      a    = w[3:0];
      b    = w[7:4];
      andn = w[11:8];
   endtask

   task automatic push_frame(logic [11:0] w);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 12; i++) exp_q.push_back(w[i]);
`ifdef SWING_TX_PARITY_EN
      exp_q.push_back(^w);
`endif
      exp_q.push_back(1'b1);
   endtask

   // Presents a triple and returns #1 after the acceptance edge.
   task automatic accept(logic [11:0] w, bit hold);
      int k;
      @(negedge clk);
      drive(w);
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("accept_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      push_frame(w);
      if (!hold) in_valid = 1'b0;
   endtask

   // Checks one whole frame from the acceptance cycle, then the idle cycle.
   task automatic check_frame(bit mangle, logic [11:0] alt);
      bit e;
      for (int bi = 0; bi < NBITS; bi++) begin
         if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 expected %0d", NBITS - bi);
            e = 1'b1;
         end else begin
            e = exp_q.pop_front();
         end
         for (int j = 0; j < CPB; j++) begin
            chk($sformatf("tx_out_bit%0d_cyc%0d", bi, j), tx_out, e);
            chk("tx_busy_frame", tx_busy, 1'b1);
            chk("in_ready_frame", in_ready, 1'b0);
            chk($sformatf("frame_done_bit%0d_cyc%0d", bi, j), frame_done,
                (bi == NBITS - 1 && j == CPB - 1));
            if (mangle && bi == 3 && j == 0) begin
               @(negedge clk);
               drive(alt);
            end
            @(posedge clk);
            #1;
         end
      end
      chk("idle_in_ready", in_ready, 1'b1);
      chk("idle_tx_out", tx_out, 1'b1);
      chk("idle_tx_busy", tx_busy, 1'b0);
      chk("idle_frame_done", frame_done, 1'b0);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      drive(12'h000);
      #2;
      chk("rst_tx_out", tx_out, 1'b1);
      chk("rst_in_ready", in_ready, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("idle20_tx_out", tx_out, 1'b1);
         chk("idle20_in_ready", in_ready, 1'b1);
         chk("idle20_tx_busy", tx_busy, 1'b0);
         chk("idle20_frame_done", frame_done, 1'b0);
      end

      // Reference word and parity patterns
      accept(12'h26B, 1'b0);
      check_frame(1'b0, 12'h000);
      accept(12'h001, 1'b0);
      check_frame(1'b0, 12'h000);
      accept(12'hFFF, 1'b0);
      check_frame(1'b0, 12'h000);

      // Back-to-back with in_valid held; inputs change mid-DATA
      accept(12'hA5C, 1'b1);
      check_frame(1'b1, 12'h3C7);
      @(posedge clk);
      #1;
      push_frame(12'h3C7);
      in_valid = 1'b0;
      check_frame(1'b0, 12'h000);

      // Asynchronous reset during data bit 5
      accept(12'h9D4, 1'b0);
      repeat (6 * CPB) @(posedge clk);
      #2;
      chk("pre_reset_bit5", tx_out, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_tx_out", tx_out, 1'b1);
      chk("midrst_tx_busy", tx_busy, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_frame_done", frame_done, 1'b0);
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         chk("rst_hold_frame_done", frame_done, 1'b0);
      end
      reset = 1'b0;
      for (int i = 0; i < 16 * CPB; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_frame_done", frame_done, 1'b0);
         chk("post_rst_tx_out", tx_out, 1'b1);
      end
      accept(12'h5E1, 1'b0);
      check_frame(1'b0, 12'h000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
